// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush sequencer: SRAM wait FSM with timeout, branch flush, load-use stall.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             freezePC,
  output logic             freezeIF,
  output logic             flushIF,
  output logic             flushID,
  output logic             freezeAll,
  output logic             memErr,
  output logic [1:0]       waitState,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                mem_err_q, mem_err_d;
  logic                freeze;

  // Wait FSM; a dropped memReq while waiting is treated as completion.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    freeze    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (memReq && !memReady) begin
          freeze  = 1'b1;
          state_d = ST_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (!memReq || memReady) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else begin
          freeze = 1'b1;
          if (wcnt_q == WCNT_W'(WAIT_MAX)) begin
            state_d   = ST_ERR;
            mem_err_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      ST_ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Mealy hazard arbitration: memory freeze > taken branch > load-use.
  always_comb begin
    freezeAll = 1'b0;
    freezePC  = 1'b0;
    freezeIF  = 1'b0;
    flushIF   = 1'b0;
    flushID   = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        freezeAll = 1'b1;
        freezePC  = 1'b1;
        freezeIF  = 1'b1;
      end else if (branchTaken) begin
        flushIF = 1'b1;
        flushID = 1'b1;
      end else if (hazard) begin
        freezePC = 1'b1;
        freezeIF = 1'b1;
        flushID  = 1'b1;
      end
    end
  end

  assign memErr    = mem_err_q;
  assign waitState = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; freezePC covers every freezeAll cycle as well.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freezePC && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flushIF && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`else
  assign stallCount = '0;
  assign flushCount = '0;
`endif

endmodule
